// File: rtl/cla_seq_adder_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
// FSM state encoding and the slice width used by cla_seq_adder and cla4_slice.
package cla_seq_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/cla_seq_adder_cla4_slice.sv
// Purely combinational 4-bit carry-lookahead slice: sum, carry into bit 3,
// carry out, and the group propagate/generate terms.
module cla4_slice
  import cla_seq_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                c3_o,
  output logic                cout_o,
  output logic                p_o,
  output logic                g_o
);

  logic [NIBBLE_W-1:0] pb;
  logic [NIBBLE_W-1:0] gb;
  logic [NIBBLE_W:0]   c;

  always_comb begin
    pb = a_i ^ b_i;
    gb = a_i & b_i;

    // c[i] is the carry into bit i, fully expanded from cin_i.
    c[0] = cin_i;
    c[1] = gb[0] | (pb[0] & cin_i);
    c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin_i);
    c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
         | (pb[2] & pb[1] & pb[0] & cin_i);

    p_o  = &pb;
    g_o  = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
         | (pb[3] & pb[2] & pb[1] & gb[0]);
    c[4] = g_o | (p_o & cin_i);

    s_o    = pb ^ c[NIBBLE_W-1:0];
    c3_o   = c[3];
    cout_o = c[4];
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Sequential adder that runs one 4-bit lookahead slice over the operands, one nibble
// per cycle. Define CLA_SEQ_SUB_EN to add the sub port (A - B via inverted B, carry-in 1).
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned NIB   = WIDTH / NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             prop
);

  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             prop_acc_q, prop_acc_d;
  logic             cout_q, cout_d;
  logic             c_msb_q, c_msb_d;
  logic             prop_q, prop_d;
`ifdef CLA_SEQ_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic [IdxW+1:0]     base;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_c3;
  logic                slice_cout;
  logic                slice_p;
  logic                slice_g;

  always_comb begin
    base  = {idx_q, 2'b00};
    a_nib = a_q[base +: NIBBLE_W];
`ifdef CLA_SEQ_SUB_EN
    b_nib = b_q[base +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
`else
    b_nib = b_q[base +: NIBBLE_W];
`endif
  end

  cla4_slice u_slice (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .cin_i  (carry_q),
    .s_o    (slice_s),
    .c3_o   (slice_c3),
    .cout_o (slice_cout),
    .p_o    (slice_p),
    .g_o    (slice_g)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    prop_acc_d = prop_acc_q;
    cout_d     = cout_q;
    c_msb_d    = c_msb_q;
    prop_d     = prop_q;
`ifdef CLA_SEQ_SUB_EN
    sub_d      = sub_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d        = a;
          b_d        = b;
`ifdef CLA_SEQ_SUB_EN
          sub_d      = sub;
          carry_d    = sub ? 1'b1 : cin;
`else
          carry_d    = cin;
`endif
          idx_d      = '0;
          sum_d      = '0;
          prop_acc_d = 1'b1;
          cout_d     = 1'b0;
          c_msb_d    = 1'b0;
          prop_d     = 1'b0;
          state_d    = StRun;
        end
      end
      StRun: begin
        sum_d[base +: NIBBLE_W] = slice_s;
        carry_d    = slice_cout;
        prop_acc_d = prop_acc_q & slice_p;
        idx_d      = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          // Final carry taken in group generate/propagate form.
          cout_d  = slice_g | (slice_p & carry_q);
          c_msb_d = slice_c3;
          prop_d  = prop_acc_q & slice_p;
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      prop_acc_q <= 1'b0;
      cout_q     <= 1'b0;
      c_msb_q    <= 1'b0;
      prop_q     <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
      sub_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      prop_acc_q <= prop_acc_d;
      cout_q     <= cout_d;
      c_msb_q    <= c_msb_d;
      prop_q     <= prop_d;
`ifdef CLA_SEQ_SUB_EN
      sub_q      <= sub_d;
`endif
    end
  end

  always_comb begin
    ready = (state_q == StIdle);
    busy  = (state_q == StRun);
    done  = (state_q == StDone);
    sum   = sum_q;
    cout  = cout_q;
    ovf   = c_msb_q ^ cout_q;
    prop  = prop_q;
  end

endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001: Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002: Parameter NIB, default WIDTH/4, number of nibble passes; SHALL be derived, not overridden.
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: start  input  1  request; sampled only in IDLE.
REQ-006: a  input  WIDTH  operand A; captured on accepted start.
REQ-007: b  input  WIDTH  operand B; captured on accepted start.
REQ-008: cin  input  1  carry-in; captured on accepted start.
REQ-009: sub  input  1  subtract select; captured on accepted start; present only when CLA_SEQ_SUB_EN is defined.
REQ-010: ready  output  1  high in IDLE; start accepted only when high.
REQ-011: busy  output  1  high in RUN.
REQ-012: done  output  1  one-cycle pulse in DONE.
REQ-013: sum  output  WIDTH  registered result; held from DONE until the next accepted start.
REQ-014: cout  output  1  carry out of bit WIDTH-1.
REQ-015: ovf  output  1  signed overflow: carry into MSB XOR cout.
REQ-016: prop  output  1  AND of the group-propagate outputs of all NIB passes.

Function
REQ-017: The FSM SHALL have states IDLE, RUN and DONE.
REQ-018: IDLE + start=1 at edge E: latch a, b and cin, clear nibble index to 0, clear sum, go to RUN.
REQ-019: In RUN, each cycle SHALL feed nibble[idx] of A, nibble[idx] of B and the carry register into one 4-bit CLA slice.
REQ-020: Each RUN edge SHALL write the slice sum into sum[4*idx+3:4*idx], load the slice cout into the carry register, AND the slice P into the prop accumulator, and increment idx.
REQ-021: On the RUN edge with idx=NIB-1, the block SHALL register the slice internal c[3] as carry-into-MSB and go to DONE.
REQ-022: Latency: done SHALL be high during exactly the cycle after edge E+NIB (cycle E+4 for WIDTH=16), then the FSM returns to IDLE.
REQ-023: cout, ovf and prop SHALL update only at the final RUN edge and hold until the next accepted start clears them.
REQ-024: start in RUN or DONE SHALL be ignored and leave no pending request; changes on a, b or cin after acceptance SHALL have no effect.
REQ-025: Arithmetic SHALL be modulo 2^WIDTH; cout is the unsigned carry; ovf = c_msb XOR cout.
REQ-026: prop=1 iff every operand bit pair differs (A XOR B all ones), independent of cin.

Reset
REQ-027: rst=1 at any edge SHALL force IDLE and clear sum, cout, ovf, prop, idx and the carry register to 0; busy=0, done=0, ready=1 from the next cycle.
REQ-028: rst SHALL take priority over start and over an in-flight RUN; an aborted operation SHALL produce no done pulse.

Configuration
REQ-029: Macro CLA_SEQ_SUB_EN defined: sub port exists; with sub=1 latched, B is inverted per nibble and the initial carry SHALL be 1 (cin ignored); cout=1 means no borrow.
REQ-030: CLA_SEQ_SUB_EN undefined: no sub port and no inversion logic; the block is add-only.

Structure
REQ-031: A shared package SHALL hold the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the constant NIBBLE_W=4.
REQ-032: The 4-bit lookahead slice SHALL be a separate sub-module cla4_slice (a, b, cin -> s, c[3], cout, P, G), instantiated once; all slice logic is combinational, all state is in cla_seq_adder.

Verification
REQ-033: a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0, ovf=0, prop=0, done exactly 4 cycles after the accepted start edge.
REQ-034: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-035: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0, prop=1.
REQ-036: CLA_SEQ_SUB_EN defined, sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0.
REQ-037: start pulsed again at RUN cycle 2 with different operands -> ignored; the first result completes unchanged, followed by a single done.
REQ-038: rst asserted at RUN cycle 2 -> IDLE next cycle, all outputs 0, ready=1, no done; a new start then completes normally.
